// File: rtl/hack_video_pkg.sv
// Shared definitions for the Hack screen scanout path: FSM state encoding
// and the default geometry of the 512x256 monochrome frame buffer.
package hack_video_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } scanout_state_e;

    localparam int WORD_BITS    = 16;
    localparam int LINE_WORDS   = 32;
    localparam int LINE_PIXELS  = LINE_WORDS * WORD_BITS;
    localparam int SCREEN_WORDS = 8192;

endpackage

// File: rtl/pixel_shift16.sv
// 16-bit load/shift register: a load captures a new word, every other enabled
// cycle shifts right by one so the LSB always presents the next pixel.
module pixel_shift16
    import hack_video_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 load,
    input  logic [WORD_BITS-1:0] din,
    output logic                 lsb
);

    logic [WORD_BITS-1:0] data_q;
    logic [WORD_BITS-1:0] data_d;

    // Next value: hold, load a fresh word, or shift toward the LSB.
    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = load ? din : (data_q >> 1);
        end
    end

    // Shift register storage, cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign lsb = data_q[0];

endmodule

// File: rtl/hack_screen_scanout.sv
// Frame buffer scanout: walks screen RAM word by word, serialises each word
// LSB-first into pixels and generates hsync/vsync/valid raster timing.
module hack_screen_scanout
    import hack_video_pkg::*;
#(
    parameter int H_WORDS     = LINE_WORDS,
    parameter int V_LINES     = 256,
    parameter int H_BLANK     = 64,
    parameter int HSYNC_LEN   = 32,
    parameter int V_BLANK     = 16,
    parameter int VSYNC_LINES = 2,
    parameter int ADDR_W      = $clog2(H_WORDS * V_LINES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              pix_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic              pixel,
    output logic              pixel_valid,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);

    localparam int CNT_W      = 16;
    localparam int LINE_PIX   = H_WORDS * WORD_BITS;
    localparam int LINE_TICKS = LINE_PIX + H_BLANK;
    localparam int SCREEN_SZ  = H_WORDS * V_LINES;

    scanout_state_e    state_q, state_d;
    logic [3:0]        bit_q, bit_d;
    logic [CNT_W-1:0]  word_q, word_d;
    logic [CNT_W-1:0]  line_q, line_d;
    logic [CNT_W-1:0]  btick_q, btick_d;
    logic [CNT_W-1:0]  bline_q, bline_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pixel_q, pixel_d;
    logic              valid_q, valid_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              fs_q, fs_d;

    logic tick_active;
    logic word_start;
    logic last_word_tick;
    logic hblank_end;
    logic vline_end;
    logic last_line;
    logic last_vline;
    logic shift_lsb;

    // An IDLE tick with enable raised is already the first pixel of the frame,
    // so the first pixel appears one cycle after that tick.
    assign tick_active    = pix_en && ((state_q == ACTIVE) || ((state_q == IDLE) && enable));
    assign word_start     = tick_active && (bit_q == 4'd0);
    assign last_word_tick = (bit_q == 4'hF) && (word_q == CNT_W'(H_WORDS - 1));
    assign hblank_end     = (btick_q == CNT_W'(H_BLANK - 1));
    assign vline_end      = (btick_q == CNT_W'(LINE_TICKS - 1));
    assign last_line      = (line_q == CNT_W'(V_LINES - 1));
    assign last_vline     = (bline_q == CNT_W'(V_BLANK - 1));

    pixel_shift16 u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_active),
        .load  (word_start),
        .din   (mem_rdata >> 1),
        .lsb   (shift_lsb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; enable only matters in IDLE and at the end of V blank.
    always_comb begin
        state_d = state_q;
        if (pix_en) begin
            case (state_q)
                IDLE:    if (enable) state_d = ACTIVE;
                ACTIVE:  if (last_word_tick) state_d = HBLANK;
                HBLANK:  if (hblank_end) state_d = last_line ? VBLANK : ACTIVE;
                VBLANK:  if (vline_end && last_vline) state_d = enable ? ACTIVE : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Counter, address and output next values; everything holds without a tick.
    always_comb begin
        bit_d   = bit_q;
        word_d  = word_q;
        line_d  = line_q;
        btick_d = btick_q;
        bline_d = bline_q;
        addr_d  = addr_q;
        pixel_d = pixel_q;
        valid_d = valid_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        fs_d    = 1'b0;
        if (pix_en) begin
            pixel_d = 1'b0;
            valid_d = 1'b0;
            hsync_d = 1'b0;
            vsync_d = 1'b0;
            if (tick_active) begin
                valid_d = 1'b1;
                pixel_d = (bit_q == 4'd0) ? mem_rdata[0] : shift_lsb;
                fs_d    = (bit_q == 4'd0) && (word_q == '0) && (line_q == '0);
                bit_d   = bit_q + 4'd1;
                if (bit_q == 4'hF) begin
                    word_d = (word_q == CNT_W'(H_WORDS - 1)) ? '0 : word_q + CNT_W'(1);
                end
                if (word_start) begin
                    addr_d = (addr_q == ADDR_W'(SCREEN_SZ - 1)) ? '0 : addr_q + ADDR_W'(1);
                end
            end else if (state_q == HBLANK) begin
                hsync_d = (btick_q < CNT_W'(HSYNC_LEN));
                btick_d = hblank_end ? '0 : btick_q + CNT_W'(1);
                if (hblank_end) begin
                    line_d = last_line ? '0 : line_q + CNT_W'(1);
                end
            end else if (state_q == VBLANK) begin
                vsync_d = (bline_q < CNT_W'(VSYNC_LINES));
                hsync_d = (btick_q >= CNT_W'(LINE_PIX)) &&
                          (btick_q < CNT_W'(LINE_PIX + HSYNC_LEN));
                btick_d = vline_end ? '0 : btick_q + CNT_W'(1);
                if (vline_end) begin
                    bline_d = last_vline ? '0 : bline_q + CNT_W'(1);
                end
            end
        end
    end

    // Counter, address and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q   <= '0;
            word_q  <= '0;
            line_q  <= '0;
            btick_q <= '0;
            bline_q <= '0;
            addr_q  <= '0;
            pixel_q <= 1'b0;
            valid_q <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            bit_q   <= bit_d;
            word_q  <= word_d;
            line_q  <= line_d;
            btick_q <= btick_d;
            bline_q <= bline_d;
            addr_q  <= addr_d;
            pixel_q <= pixel_d;
            valid_q <= valid_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
        end
    end

    assign mem_addr    = addr_q;
    assign pixel       = pixel_q;
    assign pixel_valid = valid_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Bench for hack_screen_scanout on a tiny 2x2-word screen, compared every cycle
// against a frame-position model (tick index -> line/column -> expected outputs).
module tb_hack_screen_scanout;

    localparam int H_WORDS     = 2;
    localparam int V_LINES     = 2;
    localparam int H_BLANK     = 4;
    localparam int HSYNC_LEN   = 2;
    localparam int V_BLANK     = 3;
    localparam int VSYNC_LINES = 1;
    localparam int ADDR_W      = 2;

    localparam int LINE_PIX    = H_WORDS * 16;
    localparam int LINE_TICKS  = LINE_PIX + H_BLANK;
    localparam int FRAME_TICKS = (V_LINES + V_BLANK) * LINE_TICKS;
    localparam int SCREEN      = H_WORDS * V_LINES;
    localparam int NUM_CYCLES  = 3000;

    logic              clk;
    logic              rstN;
    logic              enable;
    logic              pixEn;
    logic [ADDR_W-1:0] memAddr;
    logic [15:0]       memRdata;
    logic              pixel;
    logic              pixelValid;
    logic              hsync;
    logic              vsync;
    logic              frameStart;

    logic [15:0] ram [0:SCREEN-1];

    int compareCount;
    int mismatchCount;

    bit   running;
    bit   contAfter;
    int   tick;
    logic expPixel;
    logic expValid;
    logic expHsync;
    logic expVsync;
    logic expFs;
    int   expAddr;

    assign memRdata = ram[memAddr];

    hack_screen_scanout #(
        .H_WORDS     (H_WORDS),
        .V_LINES     (V_LINES),
        .H_BLANK     (H_BLANK),
        .HSYNC_LEN   (HSYNC_LEN),
        .V_BLANK     (V_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rstN),
        .enable      (enable),
        .pix_en      (pixEn),
        .mem_addr    (memAddr),
        .mem_rdata   (memRdata),
        .pixel       (pixel),
        .pixel_valid (pixelValid),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frameStart)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at time %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("pixel", 32'(pixel), 32'(expPixel));
        checkOutput("pixel_valid", 32'(pixelValid), 32'(expValid));
        checkOutput("hsync", 32'(hsync), 32'(expHsync));
        checkOutput("vsync", 32'(vsync), 32'(expVsync));
        checkOutput("frame_start", 32'(frameStart), 32'(expFs));
        checkOutput("mem_addr", 32'(memAddr), 32'(expAddr));
    endtask

    task automatic fillRam(input bit randomAll);
        for (int i = 0; i < SCREEN; i++) begin
            ram[i] = 16'($urandom);
        end
        if (!randomAll) begin
            ram[0] = 16'h0001;
            ram[2] = 16'h8000;
        end
    endtask

    task automatic modelReset();
        running  = 1'b0;
        contAfter = 1'b0;
        tick     = 0;
        expPixel = 1'b0;
        expValid = 1'b0;
        expHsync = 1'b0;
        expVsync = 1'b0;
        expFs    = 1'b0;
        expAddr  = 0;
    endtask

    // One pixel tick: advance the frame position, then derive every output
    // from the line/column that position falls on.
    task automatic modelTick(input bit en);
        int line;
        int col;
        int w;
        if (running) begin
            if (tick < FRAME_TICKS - 1) tick++;
            else if (contAfter) tick = 0;
            else running = 1'b0;
        end
        if (!running && en) begin
            running = 1'b1;
            tick    = 0;
        end
        if (!running) begin
            expPixel = 1'b0;
            expValid = 1'b0;
            expHsync = 1'b0;
            expVsync = 1'b0;
            expFs    = 1'b0;
            return;
        end
        if (tick == FRAME_TICKS - 1) contAfter = en;
        line = tick / LINE_TICKS;
        col  = tick % LINE_TICKS;
        if (line < V_LINES && col < LINE_PIX) begin
            w        = line * H_WORDS + col / 16;
            expPixel = ram[w][col % 16];
            expValid = 1'b1;
            expAddr  = (w + 1) % SCREEN;
        end else begin
            expPixel = 1'b0;
            expValid = 1'b0;
            expAddr  = (line < V_LINES) ? ((line + 1) * H_WORDS) % SCREEN : 0;
        end
        expHsync = (col >= LINE_PIX) && (col < LINE_PIX + HSYNC_LEN);
        expVsync = (line >= V_LINES) && (line < V_LINES + VSYNC_LINES);
        expFs    = (tick == 0);
    endtask

    // Phased stimulus: steady run, pix_en every other cycle, enable dropped
    // mid-frame and restored, then random pix_en with sticky random enable.
    task automatic applyStimulus(input int cyc);
        if (cyc < 400) begin
            pixEn  = 1'b1;
            enable = 1'b1;
        end else if (cyc < 800) begin
            pixEn  = (cyc % 2 == 0);
            enable = 1'b1;
        end else if (cyc < 1200) begin
            pixEn  = 1'b1;
            enable = !(cyc >= 850 && cyc < 1100);
        end else begin
            pixEn = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 3) enable = ~enable;
        end
    endtask

    // Reset pulse landing between clock edges; outputs must clear at once.
    task automatic midReset(input bit randomAll);
        #1;
        rstN = 1'b0;
        #1;
        modelReset();
        checkAll();
        fillRam(randomAll);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rstN   = 1'b0;
        pixEn  = 1'b0;
        enable = 1'b0;
        fillRam(1'b0);
        modelReset();
        #3;
        checkAll();
        rstN = 1'b1;
        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(negedge clk);
            applyStimulus(cyc);
            @(posedge clk);
            #1;
            if (pixEn) modelTick(enable);
            else expFs = 1'b0;
            checkAll();
            if (cyc == 1520) midReset(1'b0);
            if (cyc == 2510) midReset(1'b1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
